rx_cp_remove: RTL and testbench

- Receive-side front end of the OFDM chain; mirrors the transmitter's output stage, which adds the cyclic prefix.
- Accepts a continuous stream of time-domain complex samples on a Wishbone-style streaming slave port.
- Per OFDM symbol, discards the cyclic-prefix samples and forwards exactly NFFT samples to the downstream FFT on a Wishbone-style master port.
- Symbol geometry (NFFT, CP length) is selected by the 2-bit STD config, latched at each symbol boundary.

---
 rtl/rx_cp_remove.sv | 203 ++++++++++++++++++++
 tb/tb_rx_cp_remove.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_cp_remove.sv
// rx_cp_remove
// ------------
// Receive-side cyclic-prefix remover for the OFDM chain. Takes a continuous
// stream of complex time-domain samples on a Wishbone-style streaming slave
// port. For each OFDM symbol it drops the cyclic-prefix samples and forwards
// exactly NFFT samples to the downstream FFT on a Wishbone-style master port.
// The symbol geometry is chosen by STD, which is sampled only at symbol
// boundaries.
//
// Optional feature macro: RX_CP_REMOVE_SYMCNT_EN
//   When defined, the block adds a SYM_CNT[15:0] output that counts completed
//   symbols. The count is cleared on reset and when a frame ends.
//
// Ports:
//   CLK_I    in   1   clock; all logic runs on the rising edge
//   RST_I    in   1   asynchronous active-high reset
//   STD      in   2   standard select: 0=802.11a, 1=802.16, 2=802.22, 3=as 0
//   DAT_I    in  32   input sample {I[31:16], Q[15:0]}
//   CYC_I    in   1   input frame active
//   WE_I     in   1   write qualifier (a transfer needs WE_I=1)
//   STB_I    in   1   input sample valid
//   ACK_O    out  1   input sample accepted (combinational)
//   DAT_O    out 32   output sample (DAT_I passed through unchanged)
//   CYC_O    out  1   output frame active
//   STB_O    out  1   output sample valid
//   WE_O     out  1   same as STB_O
//   ACK_I    in   1   downstream accepted the output sample
//   SYM_ERR  out  1   one-cycle pulse: the frame ended in the middle of a symbol
//   SYM_CNT  out 16   completed-symbol count (present only with the macro)
module rx_cp_remove #(
  parameter int NFFT0 = 64,
  parameter int CP0   = 16,
  parameter int NFFT1 = 256,
  parameter int CP1   = 64,
  parameter int NFFT2 = 2048,
  parameter int CP2   = 512,
  parameter int CW    = 12
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [1:0]  STD,
  input  logic [31:0] DAT_I,
  input  logic        CYC_I,
  input  logic        WE_I,
  input  logic        STB_I,
  output logic        ACK_O,
  output logic [31:0] DAT_O,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  input  logic        ACK_I,
  output logic        SYM_ERR
`ifdef RX_CP_REMOVE_SYMCNT_EN
  ,
  output logic [15:0] SYM_CNT
`endif
);

  typedef enum logic {
    ST_CP   = 1'b0,
    ST_DATA = 1'b1
  } state_t;

  state_t         state_r;
  logic [CW-1:0]  cnt_r;
  logic [1:0]     std_r;
  logic           cyc_d_r;
  logic [31:0]    dat_r;
  logic           stb_r;
  logic           err_r;
`ifdef RX_CP_REMOVE_SYMCNT_EN
  logic [15:0]    symcnt_r;
`endif

  logic [CW-1:0]  cp_last_s;
  logic [CW-1:0]  nfft_last_s;
  logic [1:0]     std_norm_s;
  logic           ack_s;
  logic           xfer_in_s;
  logic           xfer_out_s;
  logic           cyc_fall_s;
  logic           at_start_s;

  // Last-sample counter values for the latched standard. The latch only
  // holds 0..2, so the default arm covers STD=0.
  always_comb begin
    cp_last_s   = CW'(CP0 - 1);
    nfft_last_s = CW'(NFFT0 - 1);
    case (std_r)
      2'd1: begin
        cp_last_s   = CW'(CP1 - 1);
        nfft_last_s = CW'(NFFT1 - 1);
      end
      2'd2: begin
        cp_last_s   = CW'(CP2 - 1);
        nfft_last_s = CW'(NFFT2 - 1);
      end
      default: begin
        cp_last_s   = CW'(CP0 - 1);
        nfft_last_s = CW'(NFFT0 - 1);
      end
    endcase
  end

  // The reserved code 3 is folded to 0 before it is latched.
  assign std_norm_s = (STD == 2'd3) ? 2'd0 : STD;

  // CP samples are always accepted because they are thrown away. Data
  // samples stall only while the output register is full and not draining.
  // Reset forces the acknowledge low at once, without waiting for a clock.
  assign ack_s      = ~RST_I & CYC_I & STB_I & WE_I &
                      ((state_r == ST_CP) | ~stb_r | ACK_I);
  // ack_s already includes the CYC/STB/WE qualifiers, so it is the transfer.
  assign xfer_in_s  = ack_s;
  assign xfer_out_s = stb_r & ACK_I;
  assign cyc_fall_s = cyc_d_r & ~CYC_I;
  assign at_start_s = (state_r == ST_CP) && (cnt_r == {CW{1'b0}});

  // Symbol FSM, sample counter, STD latch, output register and error pulse.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_r  <= ST_CP;
      cnt_r    <= {CW{1'b0}};
      std_r    <= 2'd0;
      cyc_d_r  <= 1'b0;
      dat_r    <= 32'd0;
      stb_r    <= 1'b0;
      err_r    <= 1'b0;
`ifdef RX_CP_REMOVE_SYMCNT_EN
      symcnt_r <= 16'd0;
`endif
    end else begin
      cyc_d_r <= CYC_I;
      err_r   <= 1'b0;

      // Single-stage output register. A reload in the same cycle as a drain
      // keeps STB_O high, which gives one sample per clock back to back.
      if (xfer_in_s && (state_r == ST_DATA)) begin
        dat_r <= DAT_I;
        stb_r <= 1'b1;
      end else if (xfer_out_s) begin
        stb_r <= 1'b0;
      end else begin
        stb_r <= stb_r;
      end

      if (cyc_fall_s) begin
        // The frame ended. Restart the symbol and flag it if the frame ended
        // part-way through. A sample already in the register still drains.
        state_r <= ST_CP;
        cnt_r   <= {CW{1'b0}};
        err_r   <= ~at_start_s;
`ifdef RX_CP_REMOVE_SYMCNT_EN
        symcnt_r <= 16'd0;
`endif
      end else if (xfer_in_s) begin
        case (state_r)
          ST_CP: begin
            if (cnt_r == cp_last_s) begin
              cnt_r   <= {CW{1'b0}};
              state_r <= ST_DATA;
            end else begin
              cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
          end
          ST_DATA: begin
            if (cnt_r == nfft_last_s) begin
              cnt_r   <= {CW{1'b0}};
              state_r <= ST_CP;
              std_r   <= std_norm_s;
`ifdef RX_CP_REMOVE_SYMCNT_EN
              symcnt_r <= symcnt_r + 16'd1;
`endif
            end else begin
              cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
          end
          default: begin
            state_r <= ST_CP;
            cnt_r   <= {CW{1'b0}};
          end
        endcase
      end else if (at_start_s) begin
        // The block is idle at a symbol boundary, so follow STD.
        std_r <= std_norm_s;
      end else begin
        std_r <= std_r;
      end
    end
  end

  assign ACK_O   = ack_s;
  assign DAT_O   = dat_r;
  assign STB_O   = stb_r;
  assign WE_O    = stb_r;
  // The output frame stays open until the last pending sample has drained.
  assign CYC_O   = ~RST_I & (CYC_I | stb_r);
  assign SYM_ERR = err_r;
`ifdef RX_CP_REMOVE_SYMCNT_EN
  assign SYM_CNT = symcnt_r;
`endif

endmodule

// File: tb/tb_rx_cp_remove.sv
// Self-checking bench for rx_cp_remove: a table of single-cycle vectors for
// handshake and reset behaviour, plus streamed sequences whose captured output
// is compared against index ranges derived from the symbol geometry.
module tb_rx_cp_remove;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  std;
  logic [31:0] dat_i;
  logic        cyc_i, we_i, stb_i, ack_i;
  logic        ack_o, cyc_o, stb_o, we_o, sym_err;
  logic [31:0] dat_o;
`ifdef RX_CP_REMOVE_SYMCNT_EN
  logic [15:0] sym_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int gcyc = 0;
  int outq[$];
  int outg[$];
  int expq[$];
  int err_pulses = 0;
  int stall_ack_data = 0;
  int cp_ack_hold = 0;

  rx_cp_remove dut (
    .CLK_I(clk), .RST_I(rst), .STD(std), .DAT_I(dat_i),
    .CYC_I(cyc_i), .WE_I(we_i), .STB_I(stb_i), .ACK_O(ack_o),
    .DAT_O(dat_o), .CYC_O(cyc_o), .STB_O(stb_o), .WE_O(we_o),
    .ACK_I(ack_i), .SYM_ERR(sym_err)
`ifdef RX_CP_REMOVE_SYMCNT_EN
    , .SYM_CNT(sym_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) gcyc <= gcyc + 1;

  typedef struct {
    logic        cyc, stb, we;
    logic [31:0] dat;
    logic        e_ack, e_cyc, e_err;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called at the negedge: record output transfers, error pulses and
  // acknowledges that were given while the output was stalled.
  task automatic mon(input bit cp);
    if (stb_o && ack_i) begin
      outq.push_back(int'(dat_o));
      outg.push_back(gcyc);
    end
    if (sym_err) err_pulses++;
    if (stb_o && !ack_i && ack_o) begin
      if (cp) cp_ack_hold++;
      else stall_ack_data++;
    end
  endtask

  task automatic tick(input bit cp);
    @(negedge clk); mon(cp);
    @(posedge clk); #1;
  endtask

  // Send n samples with values 0..n-1. STD switches to sw_std when sample
  // sw_at is offered. ACK_I is low during stream cycles [st_lo, st_hi), and,
  // when cp_gate is set, also on the first 8 positions of every 80-sample
  // symbol.
  task automatic stream(input int n, input int sw_at, input logic [1:0] sw_std,
                        input int st_lo, input int st_hi, input bit cp_gate,
                        output int ncyc);
    int sent = 0;
    int c = 0;
    bit cp;
    cyc_i = 1'b1; we_i = 1'b1;
    while (sent < n && c < 5000) begin
      if (sent == sw_at) std = sw_std;
      stb_i = 1'b1; dat_i = 32'(sent);
      cp = (sent % 80) < 16;
      ack_i = !((c >= st_lo && c < st_hi) || (cp_gate && (sent % 80) < 8));
      @(negedge clk); mon(cp);
      if (ack_o) sent++;
      @(posedge clk); #1; c++;
    end
    stb_i = 1'b0; ack_i = 1'b1; ncyc = c;
    chk("stream_len", 64'(sent), 64'(n));
  endtask

  task automatic drain();
    stb_i = 1'b0; ack_i = 1'b1;
    repeat (4) tick(1'b1);
  endtask

  task automatic idle(input int n);
    cyc_i = 1'b0; stb_i = 1'b0; ack_i = 1'b1;
    repeat (n) tick(1'b1);
  endtask

  task automatic add_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) expq.push_back(i);
  endtask

  task automatic cmp_out(input string nm);
    int bad = 0;
    chk({nm, "_count"}, 64'(outq.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size() && i < outq.size(); i++)
      if (outq[i] != expq[i]) bad++;
    chk({nm, "_data"}, 64'(bad), 64'd0);
    outq.delete(); outg.delete(); expq.delete();
  endtask

  initial begin
    int nc;
    int g0;
    rst = 1'b1; std = 2'd0; dat_i = 32'd0;
    cyc_i = 1'b0; we_i = 1'b0; stb_i = 1'b0; ack_i = 1'b0;

    // Reset values
    #3;
    chk("rst_ack", 64'(ack_o), 64'd0);
    chk("rst_stb", 64'(stb_o), 64'd0);
    chk("rst_cyc", 64'(cyc_o), 64'd0);
    chk("rst_we",  64'(we_o),  64'd0);
    chk("rst_err", 64'(sym_err), 64'd0);
    chk("rst_dat", 64'(dat_o), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Handshake vectors: idle, WE_I=0 ignored, STB_I=0, one CP sample,
    // then the frame ends after that sample, which must pulse SYM_ERR.
    //           cyc   stb   we    dat         ack   cyc_o err
    tbl[0] = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h1234,   1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 32'h0,      1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'hA,      1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0};
    ack_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc_i = tbl[i].cyc; stb_i = tbl[i].stb; we_i = tbl[i].we; dat_i = tbl[i].dat;
      @(negedge clk);
      chk($sformatf("vec%0d_ack", i), 64'(ack_o), 64'(tbl[i].e_ack));
      chk($sformatf("vec%0d_cyc", i), 64'(cyc_o), 64'(tbl[i].e_cyc));
      chk($sformatf("vec%0d_err", i), 64'(sym_err), 64'(tbl[i].e_err));
      chk($sformatf("vec%0d_stb", i), 64'(stb_o), 64'd0);
      @(posedge clk); #1;
    end

    // STD=0, one full symbol at full rate
    err_pulses = 0;
    idle(2);
    g0 = gcyc;
    stream(80, -1, 2'd0, 0, 0, 1'b0, nc);
    drain();
    chk("t1_ack_every_cycle", 64'(nc), 64'd80);
    chk("t1_first_out_cycle", 64'(outg.size() > 0 ? outg[0] - g0 : -1), 64'd17);
    chk("t1_contiguous", 64'(outg.size() == 64 ? outg[63] - outg[0] : -1), 64'd63);
    add_range(16, 79);
    cmp_out("t1");
    idle(2);
    chk("t1_no_err", 64'(err_pulses), 64'd0);

    // STD=1, three back-to-back symbols
    std = 2'd1; idle(2);
    stream(960, -1, 2'd1, 0, 0, 1'b0, nc);
    drain();
    for (int k = 0; k < 3; k++) add_range(320 * k + 64, 320 * k + 319);
    cmp_out("t2");
`ifdef RX_CP_REMOVE_SYMCNT_EN
    chk("t2_symcnt", 64'(sym_cnt), 64'd3);
`endif
    idle(2);
    chk("t2_no_err", 64'(err_pulses), 64'd0);

    // STD=0 with backpressure during DATA and during the next CP
    std = 2'd0; idle(2);
    stall_ack_data = 0; cp_ack_hold = 0;
    stream(160, -1, 2'd0, 20, 40, 1'b1, nc);
    drain();
    chk("t3_no_ack_while_full", 64'(stall_ack_data), 64'd0);
    chk("t3_cp_acked_while_stalled", 64'(cp_ack_hold), 64'd8);
    add_range(16, 79); add_range(96, 159);
    cmp_out("t3");
    idle(2);

    // STD=2, the frame ends after 600 samples
    std = 2'd2; idle(2);
    err_pulses = 0;
    stream(600, -1, 2'd2, 0, 0, 1'b0, nc);
    cyc_i = 1'b0;
    @(negedge clk);
    chk("t4_cyc_o_pending", 64'(cyc_o), 64'd1);
    mon(1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_cyc_o_done", 64'(cyc_o), 64'd0);
    mon(1'b1);
    @(posedge clk); #1;
    idle(3);
    chk("t4_err_once", 64'(err_pulses), 64'd1);
    add_range(512, 599);
    cmp_out("t4");
    stream(520, -1, 2'd2, 0, 0, 1'b0, nc);
    drain();
    add_range(512, 519);
    cmp_out("t4_restart");
    idle(3);

    // STD changes 0->1 part-way through a symbol
    std = 2'd0; idle(2);
    stream(400, 40, 2'd1, 0, 0, 1'b0, nc);
    drain();
    add_range(16, 79); add_range(144, 399);
    cmp_out("t5");
    idle(2);

    // STD=3 behaves like 0, then reset arrives in the middle of DATA
    std = 2'd3; idle(2);
    stream(80, -1, 2'd3, 0, 0, 1'b0, nc);
    drain();
    add_range(16, 79);
    cmp_out("t6");
    err_pulses = 0;
    stream(30, -1, 2'd3, 0, 0, 1'b0, nc);
    stb_i = 1'b1; ack_i = 1'b0;
    chk("t6_pre_stb", 64'(stb_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_stb", 64'(stb_o), 64'd0);
    chk("t6_async_ack", 64'(ack_o), 64'd0);
    chk("t6_async_cyc", 64'(cyc_o), 64'd0);
    chk("t6_async_err", 64'(sym_err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);
    chk("t6_no_err_after_rst", 64'(err_pulses), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
